// File: rtl/div16.sv
// Sequential restoring divider: Q8.8 dividend / Q1.7 divisor -> saturated Q8.8 quotient, one bit per clock.
// Define DIV16_ROUND_EN to round half away from zero instead of truncating toward zero.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for an operand pair
// S_CALC | shifting/subtracting one quotient bit per clock
// S_FIN  | sign, round and saturate the magnitude; register results
// S_DONE | out_valid high, results held until out_ready
module div16 #(
    parameter int DIVIDEND_W = 17,
    parameter int DIVISOR_W  = 8,
    parameter int FRAC_SHIFT = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] in_17bit,
    input  logic [DIVISOR_W-1:0]  in_8bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] out,
    output logic                  ovf,
    output logic                  div_zero
);
    localparam int NUM_W = DIVIDEND_W + FRAC_SHIFT;
    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(NUM_W);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(NUM_W - 1);
    localparam logic [NUM_W:0]        POS_MAX  = (NUM_W+1)'((1 << (DIVIDEND_W-1)) - 1);
    localparam logic [NUM_W:0]        NEG_MAX  = (NUM_W+1)'(1 << (DIVIDEND_W-1));
    localparam logic [DIVIDEND_W-1:0] POS_SAT  = {1'b0, {(DIVIDEND_W-1){1'b1}}};
    localparam logic [DIVIDEND_W-1:0] NEG_SAT  = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;
    state_t state;

    logic [CNT_W-1:0]     cnt;
    logic [NUM_W-1:0]     num;
    logic [NUM_W-1:0]     quo;
    logic [REM_W-1:0]     rem;
    logic [DIVISOR_W-1:0] dvs;
    logic                 neg;
    logic                 dz;

    logic [DIVIDEND_W-1:0] abs_dd;
    logic [DIVISOR_W-1:0]  abs_dv;
    logic [REM_W-1:0]      rem_sh;
    logic                  rem_ge;
    logic [NUM_W:0]        mag;
    logic [NUM_W:0]        mag_neg;

    always_comb begin
        // most-negative inputs map to the unsigned magnitude 2^(W-1), which still fits
        abs_dd  = in_17bit[DIVIDEND_W-1] ? -in_17bit : in_17bit;
        abs_dv  = in_8bit[DIVISOR_W-1] ? -in_8bit : in_8bit;
        rem_sh  = {rem[REM_W-2:0], num[NUM_W-1]};
        rem_ge  = rem_sh >= {1'b0, dvs};
`ifdef DIV16_ROUND_EN
        mag     = {1'b0, quo} + (NUM_W+1)'({rem, 1'b0} >= {2'b00, dvs});
`else
        mag     = {1'b0, quo};
`endif
        mag_neg = -mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            num       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            neg       <= 1'b0;
            dz        <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        num      <= {abs_dd, {FRAC_SHIFT{1'b0}}};
                        dvs      <= abs_dv;
                        neg      <= in_17bit[DIVIDEND_W-1] ^ in_8bit[DIVISOR_W-1];
                        dz       <= (in_8bit == '0);
                        quo      <= '0;
                        rem      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= (in_8bit == '0) ? S_FIN : S_CALC;
                    end
                end
                S_CALC: begin
                    num <= num << 1;
                    if (rem_ge) begin
                        rem <= rem_sh - {1'b0, dvs};
                        quo <= {quo[NUM_W-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        quo <= {quo[NUM_W-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT)
                        state <= S_FIN;
                end
                S_FIN: begin
                    out_valid <= 1'b1;
                    div_zero  <= dz;
                    if (dz) begin
                        ovf <= 1'b1;
                        out <= neg ? NEG_SAT : POS_SAT;
                    end else if (!neg) begin
                        ovf <= (mag > POS_MAX);
                        out <= (mag > POS_MAX) ? POS_SAT : mag[DIVIDEND_W-1:0];
                    end else begin
                        ovf <= (mag > NEG_MAX);
                        out <= (mag > NEG_MAX) ? NEG_SAT : mag_neg[DIVIDEND_W-1:0];
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div16.sv
// Scoreboard bench for div16: expected results come from an integer model of 128*D/d with saturation.
module tb_div16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_17bit = '0;
    logic [7:0]  in_8bit = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] out;
    logic        ovf;
    logic        div_zero;

    logic [18:0] sb[$];
    int n_vec = 0;
    int n_err = 0;

    div16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_17bit  (in_17bit),
        .in_8bit   (in_8bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // returns {div_zero, ovf, out}
    function automatic logic [18:0] model(input logic [16:0] dd, input logic [7:0] dv);
        longint a, b, num, den, mag, r;
        logic [16:0] q;
        bit neg;
        a = longint'(signed'(dd));
        b = longint'(signed'(dv));
        if (b == 0)
            return {1'b1, 1'b1, (a < 0) ? 17'h10000 : 17'h0FFFF};
        num = ((a < 0) ? -a : a) * 128;
        den = (b < 0) ? -b : b;
        mag = num / den;
        r   = num % den;
`ifdef DIV16_ROUND_EN
        if (2 * r >= den) mag++;
`endif
        neg = (a < 0) != (b < 0);
        if (!neg) begin
            if (mag > 65535) return {1'b0, 1'b1, 17'h0FFFF};
            q = 17'(mag);
        end else begin
            if (mag > 65536) return {1'b0, 1'b1, 17'h10000};
            q = 17'(-mag);
        end
        return {1'b0, 1'b0, q};
    endfunction

    task automatic run_op(input logic [16:0] dd, input logic [7:0] dv, input int hold);
        logic [18:0] exp;
        int lat;
        lat = 0;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_17bit = dd;
        in_8bit  = dv;
        in_valid = 1'b1;
        sb.push_back(model(dd, dv));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_17bit = 17'($urandom);
        in_8bit  = 8'($urandom);
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), (dv == 8'h00) ? 32'd1 : 32'd25);
        exp = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("out", 32'(out), 32'(exp[16:0]));
            chk("ovf", 32'(ovf), 32'(exp[17]));
            chk("div_zero", 32'(div_zero), 32'(exp[18]));
            if (i > 0) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (i < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_clr", 32'(out_valid), 32'd0);
        chk("in_ready_ret", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] rdv;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_flags", 32'({ovf, div_zero}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(17'h00100, 8'h40, 0);
        run_op(17'h00100, 8'hFF, 0);
        run_op(17'h1FF00, 8'h40, 0);
        run_op(17'h0FFFF, 8'h01, 0);
        run_op(17'h10000, 8'h01, 0);
        run_op(17'h10000, 8'h80, 0);
        run_op(17'h1FF00, 8'h00, 0);
        run_op(17'h00100, 8'h00, 0);
        run_op(17'h00001, 8'h03, 0);
        run_op(17'h1FFFF, 8'h03, 0);
        run_op(17'h00000, 8'h85, 0);
        run_op(17'h00A55, 8'h7F, 5);

        // abort mid-calculation; no expectation is queued for this operation
        @(negedge clk);
        in_17bit = 17'h01234;
        in_8bit  = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(17'h00300, 8'hC0, 0);

        for (int k = 0; k < 12; k++) begin
            rdv = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            run_op(17'($urandom), rdv, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
